plb_adc_user_logic: RTL and testbench
=====================================

// Module: plb_adc_user_logic
// PURPOSE
//  ADC capture counterpart of the PLB DAC core: clocks an external 10-bit parallel ADC, registers samples, buffers them in a FIFO.
//  MicroBlaze reads samples and status over the PLB IPIF slave interface (2 CE-decoded registers, [0:31] MSB-first bit order).
//  Sits in plb_adc_v1_00_a under the IPIF wrapper, same bus-side signals as the DAC core.
// PARAMETERS
//  C_SLV_DWIDTH      32  bus data width
//  C_NUM_REG         2   number of CE-decoded registers
//  C_ADC_WIDTH       10  ADC sample width
//  C_FIFO_AWIDTH     4   log2 of FIFO depth (depth 16)
//  C_CLKDIV_DEFAULT  4   DIV reset value (ADC clock half-period, in Bus2IP_Clk cycles)
// PORTS
//  Bus2IP_Clk     in   1   system clock, all logic rising-edge
//  Bus2IP_Resetn  in   1   synchronous active-low reset
//  ADC2IP_Data    in   10  ADC parallel sample, [0] = MSB
//  ADC2IP_OTR     in   1   ADC out-of-range flag
//  IP2ADC_Clk     out  1   generated ADC sample clock
//  IP2ADC_STBY    out  1   ADC standby, 1 = standby
//  Bus2IP_Data    in   32  write data
//  Bus2IP_BE      in   4   byte enables, BE[0] -> bits [0:7]
//  Bus2IP_RdCE    in   2   read CE, [0]=CTRL/STAT, [1]=DATA
//  Bus2IP_WrCE    in   2   write CE, same mapping
//  IP2Bus_Data    out  32  read data
//  IP2Bus_RdAck   out  1   read ack
//  IP2Bus_WrAck   out  1   write ack
//  IP2Bus_Error   out  1   always 0
// BEHAVIOUR
//  Reset (Bus2IP_Resetn=0 at a clock edge): RUN=0, DIV=C_CLKDIV_DEFAULT, FIFO empty, OVERRUN=0; IP2ADC_Clk=0, IP2ADC_STBY=1.
//   Bus outputs are combinational from CE inputs and read 0 when no CE is active. Reset mid-capture discards FIFO contents.
//  CTRL write (WrCE=2'b10): BE[0] lane -> bit0 RUN, bit1 CLR (self-clearing, always reads 0); BE[1] lane -> bits[8:15] DIV.
//  DIV=0 is treated as 1.
//  CTRL read: [0]RUN [8:15]DIV [16]EMPTY [17]FULL [18]OVERRUN [19:23]LEVEL (0..16); all other bits 0.
//  DATA read (RdCE=2'b01): [0:9] FIFO head sample, [10] its OTR, [16] VALID (1 if FIFO non-empty); all zeros when empty.
//   Head is popped at the clock edge ending each cycle with RdCE[1]=1. DATA write is acked and ignored.
//  IP2Bus_RdAck = |RdCE and IP2Bus_WrAck = |WrCE, same cycle (0 wait states). Sample/status read path is combinational from FIFO head.
//  Clock gen: RUN=1 -> counter counts 0..DIV-1 and IP2ADC_Clk toggles at terminal count (period 2*DIV cycles).
//   RUN=0 -> counter=0, IP2ADC_Clk=0. IP2ADC_STBY = ~RUN.
//  Capture pipeline:
//   - ADC2IP_Data and ADC2IP_OTR are registered every cycle (stage 1).
//   - On the cycle IP2ADC_Clk goes 1->0, stage 1 is pushed into the FIFO.
//   - Latency: pin to FIFO is 1 cycle, FIFO to readable is 1 cycle.
//  FIFO full and push with no pop: sample dropped, OVERRUN set (sticky). Cleared only by CLR or reset.
//  FIFO full with push and pop in the same cycle: both happen, LEVEL stays 16, no overrun.
//  FIFO empty and pop: no-op, LEVEL stays 0, pointers unchanged.
//  Push and pop in the same cycle otherwise: LEVEL unchanged.
//  CLR: flushes FIFO (pointers 0, LEVEL 0) and clears OVERRUN. CLR wins over a same-cycle push or pop. RUN/DIV from the same write still apply.
//  RUN 1->0: clock stops low, no further pushes, FIFO retained. A DIV change while running takes effect at the next terminal count.
// CONFIGURATION
//  ADC_TWOS_COMP_EN defined: sample MSB is inverted before the FIFO push (offset-binary -> two's complement), so mid-scale 0x200 reads as 0x000.
//  Not defined: raw ADC code is stored unchanged.
// TESTING
//  1 Reset held 5 cycles, then CTRL read -> RUN=0, DIV=4, EMPTY=1, LEVEL=0; IP2ADC_Clk=0, IP2ADC_STBY=1.
//  2 CTRL write RUN=1 DIV=2, ADC2IP_Data ramp 0x001,0x002,... -> IP2ADC_Clk period 4 cycles.
//    After 3 falling edges LEVEL=3; 3 DATA reads return ascending values with VALID=1; 4th read returns VALID=0, data 0.
//  3 RUN, no reads for 20 ADC periods -> FULL=1, LEVEL=16, OVERRUN=1; first DATA read returns the oldest retained sample.
//  4 FIFO full, DATA read in a push cycle -> LEVEL stays 16, OVERRUN stays 0, next read returns the next-oldest sample.
//  5 CTRL write CLR=1 while running -> next CTRL read shows LEVEL=0, OVERRUN=0, bit1=0, RUN still 1.
//  6 CTRL write BE=4'b1000 with DIV=8 -> DIV unchanged, RUN updated.
//    Build with ADC_TWOS_COMP_EN and input 0x200 -> DATA read [0:9]=0x000.

Source files
------------

// File: rtl/plb_adc_user_logic_if.sv
// IPIF slave-side bus bundle for the ADC user logic (CE-decoded registers, [0:31] MSB-first).
// master = IPIF/bus side, slave = user logic side.
interface plb_adc_user_logic_if #(
   parameter int C_SLV_DWIDTH = 32,
   parameter int C_NUM_REG    = 2
);
   logic [0:C_SLV_DWIDTH-1]   Bus2IP_Data;
   logic [0:C_SLV_DWIDTH/8-1] Bus2IP_BE;
   logic [0:C_NUM_REG-1]      Bus2IP_RdCE;
   logic [0:C_NUM_REG-1]      Bus2IP_WrCE;
   logic [0:C_SLV_DWIDTH-1]   IP2Bus_Data;
   logic                      IP2Bus_RdAck;
   logic                      IP2Bus_WrAck;
   logic                      IP2Bus_Error;

   modport master (
      output Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
      input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
   );

   modport slave (
      input  Bus2IP_Data, Bus2IP_BE, Bus2IP_RdCE, Bus2IP_WrCE,
      output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
   );
endinterface

// File: rtl/plb_adc_user_logic.sv
// ADC capture user logic: generates the ADC clock, registers samples and buffers them in a FIFO
// read over IPIF. Define ADC_TWOS_COMP_EN to store samples as two's complement (MSB inverted).
module plb_adc_user_logic #(
   parameter int C_SLV_DWIDTH     = 32,
   parameter int C_NUM_REG        = 2,
   parameter int C_ADC_WIDTH      = 10,
   parameter int C_FIFO_AWIDTH    = 4,
   parameter int C_CLKDIV_DEFAULT = 4
) (
   input  logic                   Bus2IP_Clk,
   input  logic                   Bus2IP_Resetn,
   input  logic [0:C_ADC_WIDTH-1] ADC2IP_Data,
   input  logic                   ADC2IP_OTR,
   output logic                   IP2ADC_Clk,
   output logic                   IP2ADC_STBY,
   plb_adc_user_logic_if.slave    bus
);

   localparam int DEPTH = 1 << C_FIFO_AWIDTH;
   localparam int LW    = C_FIFO_AWIDTH + 1;
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   typedef enum logic {PH_LOW, PH_HIGH} phase_t;

   logic [0:C_SLV_DWIDTH-1]   wdata;
   logic [0:C_SLV_DWIDTH/8-1] be;
   logic [0:C_NUM_REG-1]      rd_ce;
   logic [0:C_NUM_REG-1]      wr_ce;

   logic                      run;
   logic [7:0]                div;
   logic [7:0]                div_eff;
   logic [7:0]                cnt;
   phase_t                    phase;
   logic                      terminal;

   logic [0:C_ADC_WIDTH-1]    s1_data;
   logic                      s1_otr;
   logic [0:C_ADC_WIDTH]      push_word;
   logic [0:C_ADC_WIDTH]      mem [DEPTH];
   logic [0:C_ADC_WIDTH]      head;
   logic [C_FIFO_AWIDTH-1:0]  wr_ptr;
   logic [C_FIFO_AWIDTH-1:0]  rd_ptr;
   logic [LW-1:0]             level;
   logic                      overrun;
   logic                      empty;
   logic                      full;

   logic                      ctrl_wr;
   logic                      ctrl_lane0;
   logic                      clr;
   logic                      push;
   logic                      pop;
   logic                      push_ok;

   logic [0:C_SLV_DWIDTH-1]   ctrl_word;
   logic [0:C_SLV_DWIDTH-1]   data_word;
   logic                      unused_bus_bits;

   assign wdata = bus.Bus2IP_Data;
   assign be    = bus.Bus2IP_BE;
   assign rd_ce = bus.Bus2IP_RdCE;
   assign wr_ce = bus.Bus2IP_WrCE;

   assign unused_bus_bits = ^{wdata[2:7], wdata[16:C_SLV_DWIDTH-1], be[2:C_SLV_DWIDTH/8-1]};

   // ---------------- control decode ----------------
   assign ctrl_wr    = wr_ce[0];
   assign ctrl_lane0 = ctrl_wr & be[0];
   assign clr        = ctrl_lane0 & wdata[1];

   // ---------------- ADC clock generator ----------------
   assign div_eff  = (div == 8'd0) ? 8'd1 : div;
   // >= so that a DIV decrease mid-count still reaches a terminal count
   assign terminal = (cnt >= (div_eff - 8'd1));

   always_ff @(posedge Bus2IP_Clk) begin
      if (!Bus2IP_Resetn) begin
         run   <= 1'b0;
         div   <= 8'(C_CLKDIV_DEFAULT);
         cnt   <= '0;
         phase <= PH_LOW;
      end else begin
         if (ctrl_lane0) run <= wdata[0];
         if (ctrl_wr && be[1]) div <= wdata[8:15];
         if (!run) begin
            cnt   <= '0;
            phase <= PH_LOW;
         end else if (terminal) begin
            cnt   <= '0;
            phase <= (phase == PH_HIGH) ? PH_LOW : PH_HIGH;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   assign IP2ADC_Clk  = (phase == PH_HIGH);
   assign IP2ADC_STBY = ~run;

   // ---------------- capture stage ----------------
   always_ff @(posedge Bus2IP_Clk) begin
      if (!Bus2IP_Resetn) begin
         s1_data <= '0;
         s1_otr  <= 1'b0;
      end else begin
         s1_data <= ADC2IP_Data;
         s1_otr  <= ADC2IP_OTR;
      end
   end

`ifdef ADC_TWOS_COMP_EN
   assign push_word = {~s1_data[0], s1_data[1:C_ADC_WIDTH-1], s1_otr};
`else
   assign push_word = {s1_data, s1_otr};
`endif

   // ---------------- FIFO ----------------
   assign empty   = (level == '0);
   assign full    = (level == LVL_FULL);
   assign push    = run & terminal & (phase == PH_HIGH);
   assign pop     = rd_ce[1] & ~empty;
   // when full, a push only lands if the same cycle frees a slot
   assign push_ok = push & (~full | pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge Bus2IP_Clk) begin
      if (!Bus2IP_Resetn || clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
      end else begin
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (push && !push_ok) overrun <= 1'b1;
         unique case ({push_ok, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge Bus2IP_Clk) begin
      if (Bus2IP_Resetn && !clr && push_ok) mem[wr_ptr] <= push_word;
   end

   // ---------------- read path ----------------
   always_comb begin
      ctrl_word               = '0;
      ctrl_word[0]            = run;
      ctrl_word[8:15]         = div;
      ctrl_word[16]           = empty;
      ctrl_word[17]           = full;
      ctrl_word[18]           = overrun;
      ctrl_word[19 +: LW]     = level;

      data_word = '0;
      if (!empty) begin
         data_word[0 +: C_ADC_WIDTH] = head[0 +: C_ADC_WIDTH];
         data_word[C_ADC_WIDTH]      = head[C_ADC_WIDTH];
         data_word[16]               = 1'b1;
      end
   end

   always_comb begin
      bus.IP2Bus_Data = '0;
      if (rd_ce[0]) bus.IP2Bus_Data = bus.IP2Bus_Data | ctrl_word;
      if (rd_ce[1]) bus.IP2Bus_Data = bus.IP2Bus_Data | data_word;
   end

   assign bus.IP2Bus_RdAck = |rd_ce;
   assign bus.IP2Bus_WrAck = |wr_ce;
   assign bus.IP2Bus_Error = 1'b0;

endmodule

// File: tb/tb_plb_adc_user_logic.sv
// Scoreboard bench for plb_adc_user_logic: a queue-based FIFO/register model predicts every bus
// read; a monitor compares on each ack. Honours ADC_TWOS_COMP_EN in its model.
module tb_plb_adc_user_logic;

   localparam int DEPTH = 16;
`ifdef ADC_TWOS_COMP_EN
   localparam logic [0:9] TC_FLIP = 10'h200;
`else
   localparam logic [0:9] TC_FLIP = 10'h000;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [0:9] adc_data = '0;
   logic       adc_otr = 1'b0;
   logic       adc_clk;
   logic       adc_stby;

   plb_adc_user_logic_if #(.C_SLV_DWIDTH(32), .C_NUM_REG(2)) bus ();

   plb_adc_user_logic #(
      .C_SLV_DWIDTH(32), .C_NUM_REG(2), .C_ADC_WIDTH(10),
      .C_FIFO_AWIDTH(4), .C_CLKDIV_DEFAULT(4)
   ) dut (
      .Bus2IP_Clk(clk), .Bus2IP_Resetn(rstn),
      .ADC2IP_Data(adc_data), .ADC2IP_OTR(adc_otr),
      .IP2ADC_Clk(adc_clk), .IP2ADC_STBY(adc_stby),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   logic [0:10] mq[$];
   bit          m_run = 1'b0;
   bit          m_run_prev = 1'b0;
   logic [7:0]  m_div = 8'd4;
   bit          m_ovr = 1'b0;
   bit          m_rise_now = 1'b0;
   int          cyc = 0;
   int          cfg_cyc = 0;
   int          last_rise = 0;
   bit          rise_valid = 1'b0;
   int          falls = 0;
   bit          ramp_mode = 1'b0;
   logic [0:9]  ramp_val = 10'h001;
   logic        prev_clk = 1'b0;
   logic [0:10] last_pins = '0;

   function automatic logic [0:31] exp_ctrl();
      logic [0:31] w;
      w = '0;
      w[0]     = m_run;
      w[8:15]  = m_div;
      w[16]    = (mq.size() == 0);
      w[17]    = (mq.size() == DEPTH);
      w[18]    = m_ovr;
      w[19:23] = 5'(mq.size());
      return w;
   endfunction

   function automatic logic [0:31] exp_data();
      logic [0:31] w;
      w = '0;
      if (mq.size() != 0) begin
         w[0:9] = mq[0][0:9];
         w[10]  = mq[0][10];
         w[16]  = 1'b1;
      end
      return w;
   endfunction

   // Model: samples bus inputs just before each edge, reacts to the ADC clock like an ADC would.
   initial begin : ref_model
      logic [0:1]  p_rd, p_wr;
      logic [0:3]  p_be;
      logic [0:31] p_d;
      logic        p_rstn;
      bit          p_run, fall, rise, push, pop, clr, full, nrun;
      logic [7:0]  ndiv;
      logic [0:10] p_pins;
      forever begin
         @(posedge clk);
         p_rd = bus.Bus2IP_RdCE; p_wr = bus.Bus2IP_WrCE; p_be = bus.Bus2IP_BE;
         p_d = bus.Bus2IP_Data; p_rstn = rstn; p_run = m_run; p_pins = {adc_data, adc_otr};
         #1;
         cyc++;
         m_run_prev = p_run;
         m_rise_now = 1'b0;
         rise = 1'b0;
         if (!p_rstn) begin
            mq.delete();
            m_run = 1'b0; m_div = 8'd4; m_ovr = 1'b0; rise_valid = 1'b0;
         end else begin
            fall = prev_clk && !adc_clk;
            rise = !prev_clk && adc_clk;
            push = fall && p_run;
            pop  = p_rd[1];
            clr  = 1'b0; nrun = m_run; ndiv = m_div;
            if (p_wr[0]) begin
               if (p_be[0]) begin nrun = p_d[0]; clr = p_d[1]; end
               if (p_be[1]) ndiv = p_d[8:15];
            end
            if (nrun != m_run || ndiv != m_div) cfg_cyc = cyc;
            m_run = nrun; m_div = ndiv;
            if (clr) begin
               mq.delete();
               m_ovr = 1'b0;
            end else begin
               full = (mq.size() == DEPTH);
               if (pop && mq.size() > 0) void'(mq.pop_front());
               if (push) begin
                  if (full && !pop) m_ovr = 1'b1;
                  else mq.push_back(last_pins ^ {TC_FLIP, 1'b0});
               end
            end
            if (push) falls++;
            if (rise) begin
               if (rise_valid && cfg_cyc < last_rise)
                  check("adc_clk_period", 32'(cyc - last_rise), 32'(2 * ((m_div == 0) ? 1 : int'(m_div))));
               rise_valid = 1'b1; last_rise = cyc; m_rise_now = 1'b1;
            end
            if (!m_run) rise_valid = 1'b0;
         end
         prev_clk  = adc_clk;
         last_pins = p_pins;
         if (ramp_mode) begin
            if (rise) begin adc_data = ramp_val; adc_otr = 1'b0; ramp_val = ramp_val + 10'd1; end
         end else begin
            adc_data = 10'($urandom); adc_otr = 1'($urandom);
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [0:31] data;
      bit          is_rd;
      int          tag;
   } exp_t;
   exp_t sb[$];

   function automatic string tag_name(input int t);
      case (t)
         0: return "ctrl_rd";
         1: return "data_rd";
         2: return "ctrl_wr";
         default: return "data_wr";
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (cyc > 0) begin
         if (bus.IP2Bus_RdAck || bus.IP2Bus_WrAck) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ack: got rd=%b wr=%b expected none", bus.IP2Bus_RdAck, bus.IP2Bus_WrAck);
            end else begin
               e = sb.pop_front();
               check({tag_name(e.tag), "_ack"}, 32'({bus.IP2Bus_RdAck, bus.IP2Bus_WrAck}),
                     e.is_rd ? 32'd2 : 32'd1);
               check(tag_name(e.tag), bus.IP2Bus_Data, e.data);
            end
         end else begin
            check("idle_data", bus.IP2Bus_Data, 32'h0);
         end
         check("error", 32'(bus.IP2Bus_Error), 32'h0);
         check("stby", 32'(adc_stby), 32'(!m_run));
         if (!m_run && !m_run_prev) check("adc_clk_stopped", 32'(adc_clk), 32'h0);
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic bus_idle();
      bus.Bus2IP_Data = '0; bus.Bus2IP_BE = '0; bus.Bus2IP_RdCE = '0; bus.Bus2IP_WrCE = '0;
   endtask

   task automatic ctrl_wr(input bit run, input bit clr, input logic [7:0] div, input logic [0:3] be);
      logic [0:31] d;
      d = '0; d[0] = run; d[1] = clr; d[8:15] = div;
      bus.Bus2IP_Data = d; bus.Bus2IP_BE = be; bus.Bus2IP_WrCE = 2'b10;
      sb.push_back('{data: 32'h0, is_rd: 1'b0, tag: 2});
      step(); bus_idle();
   endtask

   task automatic data_wr();
      bus.Bus2IP_Data = $urandom; bus.Bus2IP_BE = 4'hF; bus.Bus2IP_WrCE = 2'b01;
      sb.push_back('{data: 32'h0, is_rd: 1'b0, tag: 3});
      step(); bus_idle();
   endtask

   task automatic ctrl_rd();
      sb.push_back('{data: exp_ctrl(), is_rd: 1'b1, tag: 0});
      bus.Bus2IP_RdCE = 2'b10;
      step(); bus_idle();
   endtask

   task automatic data_rd();
      sb.push_back('{data: exp_data(), is_rd: 1'b1, tag: 1});
      bus.Bus2IP_RdCE = 2'b01;
      step(); bus_idle();
   endtask

   task automatic wait_falls(input int n, input int budget);
      int target, k;
      target = falls + n; k = 0;
      while (falls < target && k < budget) begin step(); k++; end
      if (falls < target) begin
         checks++; errors++;
         $display("FAIL wait_falls: got %0d falls expected %0d within %0d cycles", falls, target, budget);
      end
   endtask

   task automatic wait_level(input int lvl, input int budget);
      int k;
      k = 0;
      while (mq.size() != lvl && k < budget) begin step(); k++; end
      if (mq.size() != lvl) begin
         checks++; errors++;
         $display("FAIL wait_level: got %0d expected %0d within %0d cycles", mq.size(), lvl, budget);
      end
   endtask

   task automatic wait_rise(input int budget);
      int k;
      k = 0;
      while (!m_rise_now && k < budget) begin step(); k++; end
      if (!m_rise_now) begin
         checks++; errors++;
         $display("FAIL wait_rise: got no ADC clock rise expected one within %0d cycles", budget);
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus_idle();
      rstn = 1'b0;
      repeat (5) @(posedge clk);
      #2 rstn = 1'b1;

      // reset state
      ctrl_rd();

      // ramp capture, DIV=2
      ramp_val = 10'h001; ramp_mode = 1'b1;
      ctrl_wr(1'b1, 1'b0, 8'd2, 4'b1100);
      wait_falls(3, 40);
      ctrl_wr(1'b0, 1'b0, 8'd2, 4'b1100);
      ctrl_rd();
      repeat (4) data_rd();
      ramp_mode = 1'b0;

      // fill past full: overrun, oldest retained
      ctrl_wr(1'b1, 1'b1, 8'd2, 4'b1100);
      repeat (84) step();
      ctrl_rd();
      data_rd();
      data_rd();

      // full FIFO, read coinciding with a push
      ctrl_wr(1'b1, 1'b1, 8'd2, 4'b1100);
      wait_level(16, 120);
      wait_rise(10);
      step();
      data_rd();
      ctrl_rd();
      data_rd();

      // CLR while running
      ctrl_wr(1'b1, 1'b1, 8'd2, 4'b1100);
      ctrl_rd();

      // BE[1] off: DIV untouched, RUN updated
      ctrl_wr(1'b0, 1'b0, 8'd8, 4'b1000);
      ctrl_rd();

      // mid-scale code
      ctrl_wr(1'b0, 1'b1, 8'd2, 4'b1100);
      ramp_val = 10'h200; ramp_mode = 1'b1;
      ctrl_wr(1'b1, 1'b0, 8'd2, 4'b1100);
      wait_falls(1, 20);
      ctrl_wr(1'b0, 1'b0, 8'd2, 4'b1100);
      data_rd();
      data_rd();
      ramp_mode = 1'b0;

      // randomized traffic, including DIV 0/1 and partial byte enables
      ctrl_wr(1'b1, 1'b1, 8'd3, 4'b1100);
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0:       ctrl_wr($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                             8'($urandom_range(0, 6)), 4'($urandom));
            1, 2:    ctrl_rd();
            3, 4, 5: data_rd();
            6:       data_wr();
            default: step();
         endcase
      end

      bus_idle();
      repeat (3) step();
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
